// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_regfile_pkg;

  // Frame state: waiting for first sclk edge, shifting command byte, data bytes
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Value returned when reading address 0
  localparam logic [7:0] CHIP_ID        = 8'hC5;
  // select_reg value whenever the pointer is not in the analog range
  localparam logic [2:0] DEFAULT_SELECT = 3'b111;

endpackage

// File: rtl/spi_regfile_ctrl_edge_sync.sv
// Synchronises sclk/serial_in into iclk and flags sclk rising/falling edges.
// Latency: edge pulse is valid SYNC_STAGES iclk after the pin changes (consumed on the next edge).
// Backpressure: none; edges are reported unconditionally.
//
// Ports:
//   iclk, rstn        : core clock, synchronous active-low reset
//   sclk, serial_in   : asynchronous SPI pins
//   sclk_rise/fall    : one-iclk edge pulses of synchronised sclk
//   sdi               : serial_in synchronised through the same depth as sclk
module spi_edge_sync
  import spi_regfile_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic iclk,
  input  logic rstn,
  input  logic sclk,
  input  logic serial_in,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic sdi
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sclk_d;

  always_ff @(posedge iclk) begin
    if (!rstn) begin
      sclk_sync <= '0;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync[0] <= sclk;
      sdi_sync[0]  <= serial_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        sdi_sync[i]  <= sdi_sync[i-1];
      end
      sclk_d <= sclk_sync[SYNC_STAGES-1];
    end
  end

  // Data goes through the same depth as sclk so the sampled bit lines up with its edge
  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_d;
  assign sdi       = sdi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_regfile_ctrl.sv
// SPI register-file controller: oversampled SPI slave with burst write/read and pointer auto-increment.
// Latency: byte written to wreg_q / byte_valid one iclk after the 8th bit is captured (SYNC_STAGES+2 after pin).
// Backpressure: none; master must respect sclk half-period >= SYNC_STAGES+2 iclk.
//
// Ports:
//   iclk, rstn        : core clock, synchronous active-low reset
//   sclk, serial_in   : SPI clock and PICO (asynchronous)
//   serial_out        : POCI readback, MSB first
//   wreg_q            : control registers, address k+1 at bits [8k+7:8k]
//   load_cnt_ser      : one-hot analog register select for the current pointer
//   select_reg        : byte index inside the selected analog register
//   byte_data         : last analog data byte written
//   byte_valid        : one-iclk pulse when byte_data is ready for the analog load
module spi_regfile_ctrl
  import spi_regfile_pkg::*;
#(
  parameter int NUM_WREGS        = 3,
  parameter int NUM_ANALOG       = 8,
  parameter int BYTES_PER_ANALOG = 7,
  parameter int IDLE_TIMEOUT     = 16,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                   iclk,
  input  logic                   rstn,
  input  logic                   sclk,
  input  logic                   serial_in,
  output logic                   serial_out,
  output logic [NUM_WREGS*8-1:0] wreg_q,
  output logic [NUM_ANALOG-1:0]  load_cnt_ser,
  output logic [2:0]             select_reg,
  output logic [7:0]             byte_data,
  output logic                   byte_valid
);

  localparam int LAST_ADDR = NUM_WREGS + NUM_ANALOG * BYTES_PER_ANALOG;
  localparam int TW        = $clog2(IDLE_TIMEOUT + 1);

  if (LAST_ADDR + 1 > 128 || BYTES_PER_ANALOG > 7 || IDLE_TIMEOUT < 4) begin : g_param_check
    $error("spi_regfile_ctrl: parameter set out of range");
  end

  state_t                state, state_nxt;
  logic                  sclk_rise, sclk_fall, sdi;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift_q;
  logic                  byte_done;
  logic [6:0]            ptr;
  logic                  ptr_inc;
  logic                  rd_frame;
  logic [7:0]            rd_shift;
  logic [TW-1:0]         idle_cnt;
  logic                  timeout;
  logic                  an_hit;
  logic [NUM_ANALOG-1:0] an_load;
  logic [2:0]            an_sel;
  int                    ptr_i;
  int                    off;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .iclk      (iclk),
    .rstn      (rstn),
    .sclk      (sclk),
    .serial_in (serial_in),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .sdi       (sdi)
  );

  // A detected edge in the same cycle suppresses the timeout, so the frame continues
  assign timeout = (state != IDLE) && !(sclk_rise || sclk_fall) &&
                   (idle_cnt >= TW'(IDLE_TIMEOUT - 1));

  // Readback value for an address: chip id at 0, wregs, zero everywhere else
  function automatic logic [7:0] read_byte(input logic [6:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == 7'd0) v = CHIP_ID;
    for (int k = 0; k < NUM_WREGS; k++) begin
      if (a == 7'(k + 1)) v = wreg_q[8*k +: 8];
    end
    return v;
  endfunction

  // Analog decode of the current pointer
  always_comb begin
    an_hit  = 1'b0;
    an_load = '0;
    an_sel  = DEFAULT_SELECT;
    off     = 0;
    ptr_i   = int'(ptr);
    if (ptr_i > NUM_WREGS && ptr_i <= LAST_ADDR) begin
      off     = ptr_i - (NUM_WREGS + 1);
      an_hit  = 1'b1;
      an_load = NUM_ANALOG'(1) << (off / BYTES_PER_ANALOG);
      an_sel  = 3'(off % BYTES_PER_ANALOG);
    end
  end

  always_ff @(posedge iclk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sclk_rise) state_nxt = CMD;
      CMD:     if (timeout) state_nxt = IDLE;
               else if (byte_done) state_nxt = DATA;
      DATA:    if (timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!rstn) begin
      bit_cnt      <= '0;
      shift_q      <= '0;
      byte_done    <= 1'b0;
      ptr          <= '0;
      ptr_inc      <= 1'b0;
      rd_frame     <= 1'b0;
      rd_shift     <= '0;
      idle_cnt     <= '0;
      serial_out   <= 1'b0;
      wreg_q       <= '0;
      load_cnt_ser <= '0;
      select_reg   <= DEFAULT_SELECT;
      byte_data    <= '0;
      byte_valid   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      ptr_inc    <= 1'b0;
      byte_done  <= sclk_rise && (bit_cnt == 3'd7);

      if (sclk_rise || sclk_fall)          idle_cnt <= '0;
      else if (idle_cnt != TW'(IDLE_TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;

      if (sclk_rise) begin
        shift_q <= {shift_q[6:0], sdi};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (sclk_fall) begin
        serial_out <= rd_shift[7];
        rd_shift   <= {rd_shift[6:0], 1'b0};
      end

      // Command byte complete: shift_q holds R/W and start address
      if (byte_done && state == CMD) begin
        ptr      <= shift_q[6:0];
        rd_frame <= shift_q[7];
        rd_shift <= shift_q[7] ? read_byte(shift_q[6:0]) : 8'h00;
      end

      if (byte_done && state == DATA) begin
        ptr_inc <= 1'b1;
        if (!rd_frame) begin
          for (int k = 0; k < NUM_WREGS; k++) begin
            if (ptr == 7'(k + 1)) wreg_q[8*k +: 8] <= shift_q;
          end
          if (an_hit) begin
            byte_data  <= shift_q;
            byte_valid <= 1'b1;
          end
        end
      end

      // Pointer advances one cycle after the byte so the analog select stays stable over byte_valid
      if (ptr_inc) begin
        ptr <= ptr + 7'd1;
        if (rd_frame) rd_shift <= read_byte(ptr + 7'd1);
      end

      load_cnt_ser <= (state == DATA) ? an_load : '0;
      select_reg   <= (state == DATA) ? an_sel  : DEFAULT_SELECT;

      if (timeout) begin
        bit_cnt      <= '0;
        shift_q      <= '0;
        byte_done    <= 1'b0;
        ptr_inc      <= 1'b0;
        rd_frame     <= 1'b0;
        rd_shift     <= '0;
        serial_out   <= 1'b0;
        load_cnt_ser <= '0;
        select_reg   <= DEFAULT_SELECT;
      end
    end
  end

endmodule
